// File: rtl/conv_post_pkg.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | conv_post_pkg: shared widths and requantisation helpers for conv_post.   |
// | Revision: 1.0                                                            |
// +--------------------------------------------------------------------------+
package conv_post_pkg;

  localparam int DEF_CONV_OUT_NUM = 18;
  localparam int DEF_DATA_WIDTH   = 8;
  localparam int DEF_PSUM_WIDTH   = 24;
  localparam int DEF_BIAS_WIDTH   = 16;
  localparam int DEF_ACC_WIDTH    = 32;
  localparam int DEF_SHIFT_WIDTH  = 5;
  localparam int DEF_CNT_WIDTH    = 9;

  // Intermediate width wide enough that rounding never overflows.
  localparam int CALC_WIDTH = 64;

  localparam int SAT_MAX = (1 << (DEF_DATA_WIDTH - 1)) - 1;
  localparam int SAT_MIN = -(1 << (DEF_DATA_WIDTH - 1));

  typedef logic signed [CALC_WIDTH-1:0] calc_t;

  // Round half up, then arithmetic right shift.
  function automatic calc_t round_shift(input calc_t value, input logic [31:0] shift);
    calc_t half;
    if (shift == 32'd0) begin
      round_shift = value;
    end else begin
      half        = calc_t'(1) <<< (shift - 32'd1);
      round_shift = (value + half) >>> shift;
    end
  endfunction

  function automatic calc_t sat(input calc_t value, input int dw);
    calc_t hi;
    calc_t lo;
    hi = (calc_t'(1) <<< (dw - 1)) - calc_t'(1);
    lo = -(calc_t'(1) <<< (dw - 1));
    if (value > hi) begin
      sat = hi;
    end else if (value < lo) begin
      sat = lo;
    end else begin
      sat = value;
    end
  endfunction

endpackage
`default_nettype wire

// File: rtl/conv_requant_lane.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | conv_requant_lane: one lane of ReLU, round-shift and saturation.         |
// | Revision: 1.0                                                            |
// +--------------------------------------------------------------------------+
module conv_requant_lane
  import conv_post_pkg::*;
#(
  parameter int DATA_WIDTH  = DEF_DATA_WIDTH,
  parameter int SUM_WIDTH   = DEF_ACC_WIDTH + 1,
  parameter int SHIFT_WIDTH = DEF_SHIFT_WIDTH
) (
  input  logic                          clk,
  input  logic                          rstn,
  input  logic                          en_b,
  input  logic                          en_c,
  input  logic                          relu_en,
  input  logic [SHIFT_WIDTH-1:0]        quant_shift,
  input  logic signed [SUM_WIDTH-1:0]   sum_in,
  output logic signed [DATA_WIDTH-1:0]  data_out
);

  calc_t                       relu_val;
  logic signed [SUM_WIDTH-1:0] r_q;

  always_comb begin
    relu_val = calc_t'(sum_in);
    if (relu_en && sum_in[SUM_WIDTH-1]) begin
      relu_val = '0;
    end
  end

  // A rounded, shifted value never needs more bits than the unshifted sum.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      r_q      <= '0;
      data_out <= '0;
    end else begin
      if (en_b) begin
        r_q <= SUM_WIDTH'(round_shift(relu_val, 32'(quant_shift)));
      end
      if (en_c) begin
        data_out <= DATA_WIDTH'(sat(calc_t'(r_q), DATA_WIDTH));
      end
    end
  end

endmodule
`default_nettype wire

// File: rtl/conv_post_process.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | conv_post_process: psum accumulate, bias, requant and pixel framing.     |
// | Revision: 1.0                                                            |
// +--------------------------------------------------------------------------+
module conv_post_process
  import conv_post_pkg::*;
#(
  parameter int CONV_OUT_NUM = DEF_CONV_OUT_NUM,
  parameter int DATA_WIDTH   = DEF_DATA_WIDTH,
  parameter int PSUM_WIDTH   = DEF_PSUM_WIDTH,
  parameter int BIAS_WIDTH   = DEF_BIAS_WIDTH,
  parameter int ACC_WIDTH    = DEF_ACC_WIDTH,
  parameter int SHIFT_WIDTH  = DEF_SHIFT_WIDTH,
  parameter int CNT_WIDTH    = DEF_CNT_WIDTH
) (
  input  logic                             clk,
  input  logic                             rstn,
  input  logic [CONV_OUT_NUM*PSUM_WIDTH-1:0] psum_in,
  input  logic                             psum_valid,
  input  logic                             psum_first,
  input  logic                             psum_last,
  input  logic [CONV_OUT_NUM*BIAS_WIDTH-1:0] bias_in,
  input  logic [SHIFT_WIDTH-1:0]           quant_shift,
  input  logic                             relu_en,
  input  logic [CNT_WIDTH-1:0]             row_len_ctrl,
  input  logic [CNT_WIDTH-1:0]             row_num_ctrl,
  input  logic                             cnt_rst,
  output logic [CONV_OUT_NUM*DATA_WIDTH-1:0] data_out,
  output logic                             valid_out,
  output logic                             eol_out,
  output logic                             eof_out,
  output logic                             err_out
);

  localparam int SUM_WIDTH = ACC_WIDTH + 1;

  logic                 acc_open;
  logic                 s1_valid;
  logic                 s2_valid;
  logic [CNT_WIDTH-1:0] col_cnt;
  logic [CNT_WIDTH-1:0] row_cnt;
  logic                 beat;
  logic                 take_first;
  logic                 proto_err;
  logic                 eol_next;
  logic                 eof_next;

  always_comb begin
    beat       = psum_valid && !cnt_rst;
    // A stray continuation beat is recovered by treating it as a fresh pixel.
    take_first = psum_first || !acc_open;
    // Error when first disagrees with the open state: restart mid-pixel, or
    // continuation with nothing open.
    proto_err  = beat && (psum_first == acc_open);
    eol_next   = (row_len_ctrl <= CNT_WIDTH'(1)) ||
                 (col_cnt >= row_len_ctrl - CNT_WIDTH'(1));
    eof_next   = eol_next && ((row_num_ctrl <= CNT_WIDTH'(1)) ||
                              (row_cnt >= row_num_ctrl - CNT_WIDTH'(1)));
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      acc_open  <= 1'b0;
      s1_valid  <= 1'b0;
      s2_valid  <= 1'b0;
      valid_out <= 1'b0;
      eol_out   <= 1'b0;
      eof_out   <= 1'b0;
      err_out   <= 1'b0;
      col_cnt   <= '0;
      row_cnt   <= '0;
    end else if (cnt_rst) begin
      acc_open  <= 1'b0;
      s1_valid  <= 1'b0;
      s2_valid  <= 1'b0;
      valid_out <= 1'b0;
      eol_out   <= 1'b0;
      eof_out   <= 1'b0;
      col_cnt   <= '0;
      row_cnt   <= '0;
    end else begin
      if (beat) begin
        acc_open <= !psum_last;
      end
      if (proto_err) begin
        err_out <= 1'b1;
      end
      s1_valid  <= beat && psum_last;
      s2_valid  <= s1_valid;
      valid_out <= s2_valid;
      eol_out   <= s2_valid && eol_next;
      eof_out   <= s2_valid && eof_next;
      if (s2_valid) begin
        if (eof_next) begin
          col_cnt <= '0;
          row_cnt <= '0;
        end else if (eol_next) begin
          col_cnt <= '0;
          row_cnt <= row_cnt + CNT_WIDTH'(1);
        end else begin
          col_cnt <= col_cnt + CNT_WIDTH'(1);
        end
      end
    end
  end

  for (genvar k = 0; k < CONV_OUT_NUM; k++) begin : g_lane
    logic signed [PSUM_WIDTH-1:0] psum_k;
    logic signed [BIAS_WIDTH-1:0] bias_k;
    logic signed [ACC_WIDTH-1:0]  acc;
    logic signed [ACC_WIDTH-1:0]  tile;
    logic signed [SUM_WIDTH-1:0]  sum;

    assign psum_k = psum_in[k*PSUM_WIDTH +: PSUM_WIDTH];
    assign bias_k = bias_in[k*BIAS_WIDTH +: BIAS_WIDTH];

    always_comb begin
      tile = ACC_WIDTH'(psum_k);
      if (!take_first) begin
        tile = acc + ACC_WIDTH'(psum_k);
      end
    end

    always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
        acc <= '0;
        sum <= '0;
      end else if (beat) begin
        acc <= tile;
        if (psum_last) begin
          sum <= SUM_WIDTH'(tile) + SUM_WIDTH'(bias_k);
        end
      end
    end

    conv_requant_lane #(
      .DATA_WIDTH  (DATA_WIDTH),
      .SUM_WIDTH   (SUM_WIDTH),
      .SHIFT_WIDTH (SHIFT_WIDTH)
    ) u_lane (
      .clk         (clk),
      .rstn        (rstn),
      .en_b        (s1_valid),
      .en_c        (s2_valid),
      .relu_en     (relu_en),
      .quant_shift (quant_shift),
      .sum_in      (sum),
      .data_out    (data_out[k*DATA_WIDTH +: DATA_WIDTH])
    );
  end

endmodule
`default_nettype wire

// File: doc/conv_post_process.md
Name: conv_post_process

Overview:
- Output-side counterpart of the conv pre-processing stage.
- Accepts per-output-channel partial sums from the APM multiply array. Accumulates them across input-channel tiles, adds bias, applies optional ReLU, then rounds, shifts and saturates to DATA_WIDTH.
- Emits a CONV_OUT_NUM-lane pixel stream in the same format the pre-processing stage consumes, so layers chain directly.
- Tracks output column/row position and flags end-of-row and end-of-frame.

Parameters:
- CONV_OUT_NUM, 18, number of output channels (lanes) processed in parallel.
- DATA_WIDTH, 8, signed output activation width.
- PSUM_WIDTH, 24, signed width of each incoming partial sum.
- BIAS_WIDTH, 16, signed bias width, already aligned to the accumulator scale.
- ACC_WIDTH, 32, signed accumulator width.
- SHIFT_WIDTH, 5, width of the requantisation right-shift amount.
- CNT_WIDTH, 9, width of the column/row length controls and counters.

Ports:
- clk  in  1  system clock, all logic on rising edge.
- rstn  in  1  asynchronous active-low reset.
- psum_in  in  CONV_OUT_NUM*PSUM_WIDTH  partial sums, lane k at bits [k*PSUM_WIDTH +: PSUM_WIDTH].
- psum_valid  in  1  psum_in/flags valid this cycle.
- psum_first  in  1  first input-channel tile of the current output pixel.
- psum_last  in  1  last input-channel tile of the current output pixel.
- bias_in  in  CONV_OUT_NUM*BIAS_WIDTH  per-lane bias, sampled on the psum_last beat.
- quant_shift  in  SHIFT_WIDTH  requant right shift; static while a frame is in flight.
- relu_en  in  1  enable ReLU; static while a frame is in flight.
- row_len_ctrl  in  CNT_WIDTH  output pixels per row.
- row_num_ctrl  in  CNT_WIDTH  output rows per frame.
- cnt_rst  in  1  synchronous clear of counters and accumulation state.
- data_out  out  CONV_OUT_NUM*DATA_WIDTH  quantised pixel, lane order as psum_in.
- valid_out  out  1  data_out valid.
- eol_out  out  1  qualifies valid_out: last pixel of a row.
- eof_out  out  1  qualifies valid_out: last pixel of the frame.
- err_out  out  1  sticky protocol error.

Behaviour:

Reset and clear
- rstn low (async): all outputs 0, accumulators 0, acc_open 0, all pipeline valids 0, counters 0.
- In-flight data is discarded. No output is produced until new psum beats arrive.

Stage A, accumulate (per lane)
- On psum_valid with psum_first: acc <= sext(psum).
- On psum_valid without psum_first: acc <= acc + sext(psum).
- acc_open is set on a beat without psum_last and cleared on a psum_last beat.
- psum_first and psum_last in the same beat: single-tile pixel.

Stage A to B
- On a psum_last beat, register sum = (first ? sext(psum) : acc + sext(psum)) + sext(bias_in); s1_valid = 1.

Stage B, requant lane, stage 1
- If relu_en and sum < 0, value = 0.
- If quant_shift > 0: r = (value + 2^(quant_shift-1)) >>> quant_shift (round half up, arithmetic shift).
- Otherwise r = value.

Stage C, requant lane, stage 2
- Saturate r to [-2^(DATA_WIDTH-1), 2^(DATA_WIDTH-1)-1], giving [-128, 127] at default width.
- Register data_out and valid_out.

Latency
- psum_last beat at cycle t produces valid_out at t+3.
- Fully pipelined; one pixel per cycle sustained.
- Non-last beats produce no output.

Counters (advance only on valid_out)
- col_cnt increments per output.
- eol_out = 1 when col_cnt == row_len_ctrl-1; col_cnt then wraps to 0 and row_cnt increments.
- eof_out = 1 on the eol pixel where row_cnt == row_num_ctrl-1; both counters then wrap to 0.
- row_len_ctrl = 0 or 1 means every output is eol; row_num_ctrl = 0 behaves as 1.

Protocol errors (err_out sticky, cleared only by rstn)
- psum_valid without psum_first while acc_open = 0: set err_out, treat the beat as first.
- psum_first while acc_open = 1: set err_out, discard the old accumulation, restart.

cnt_rst
- Clears counters, acc_open and all stage valids on the next edge.
- An output in stage C that same cycle is suppressed.
- Psum beats in the same cycle are ignored.

Simultaneous events
- A psum_last beat and an output on valid_out in the same cycle are independent; both proceed.

Decomposition:
- Package conv_post_pkg holds:
  - default widths;
  - saturation bound constants SAT_MAX and SAT_MIN as functions of DATA_WIDTH;
  - function round_shift(value, shift);
  - function sat(value).
- Sub-module conv_requant_lane: one lane of stages B–C (ReLU, round-shift, saturate, 2 register stages), generated CONV_OUT_NUM times.
- Accumulators, counters and error logic live in the top.

Test Plan:
1. Single tile: lane0 psum = 1000, bias = 24, shift = 4, relu_en = 0, first = last = 1 → data_out lane0 = 64 at t+3, valid_out high for 1 cycle.
2. Three tiles: psums 100, -50, 30, bias 0, shift 0 → lane output 80 on the cycle 3 after the last beat. Also feed 200, 100 (sum 300) → saturates to 127. Feed -300 → saturates to -128.
3. ReLU plus rounding: sum = -77 with relu_en = 1 → 0. Sum = 24 with shift 4 → (24+8) >> 4 = 2. Sum = 23 with shift 4 → 1.
4. Framing: row_len_ctrl = 4, row_num_ctrl = 2, 8 single-tile pixels back-to-back → eol_out on outputs 4 and 8, eof_out only on output 8. A ninth pixel restarts at col 0 with no flags.
5. Protocol errors:
   - beat with first = 0 after reset → err_out = 1, beat taken as first, output still correct;
   - first asserted mid-accumulation → previous partial discarded.
6. Reset mid-stream: rstn low for 1 cycle one cycle after a psum_last beat → no valid_out appears, counters 0, err_out 0. The next pixel starts at col 0.
